// File: rtl/seq_pattern_scheduler_if.sv
// Bus bundle between the pattern scheduler and its controller.
// Holds pattern-memory writes, transport controls, tone/sweep configuration,
// and the signals that drive the sequencer and report status.
interface seq_pattern_scheduler_if #(
   parameter int ADDR_W = 4
);
   logic              pat_we;
   logic [ADDR_W-1:0] pat_addr;
   logic [7:0]        pat_data;
   logic [ADDR_W-1:0] cfg_len;
   logic              start;
   logic              stop;
   logic              bar_tick;
   logic              cfg_req;
   logic [3:0]        freq_sel;
   logic [2:0]        sweep_sel;
   logic [7:0]        kbd_out;
   logic [7:0]        freqin_out;
   logic              sel_snd_out;
   logic              sel_loop_out;
   logic [ADDR_W-1:0] step_idx;
   logic              busy;
   logic              cfg_pending;
   logic              done;

   modport master (
      output pat_we, pat_addr, pat_data, cfg_len, start, stop, bar_tick,
             cfg_req, freq_sel, sweep_sel,
      input  kbd_out, freqin_out, sel_snd_out, sel_loop_out, step_idx,
             busy, cfg_pending, done
   );

   modport slave (
      input  pat_we, pat_addr, pat_data, cfg_len, start, stop, bar_tick,
             cfg_req, freq_sel, sweep_sel,
      output kbd_out, freqin_out, sel_snd_out, sel_loop_out, step_idx,
             busy, cfg_pending, done
   );
endinterface

// File: rtl/seq_pattern_scheduler.sv
// Pattern scheduler: plays a table of 8-bit step masks into a sequencer,
// advancing one entry per bar, and reloads tone/sweep settings at bar
// boundaries whenever a new configuration has been latched.
// Optional macro SEQ_SCHED_ONESHOT_EN: stop after the last entry and pulse
// done; otherwise playback loops forever and done is held low.
module seq_pattern_scheduler #(
   parameter int ADDR_W = 4
) (
   input logic                    clk,
   input logic                    rst,
   seq_pattern_scheduler_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, LOAD_SND, LOAD_LOOP, PLAY} state_t;

   state_t            state, state_nxt;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] step_idx_q, step_nxt;
   logic [3:0]        freq_reg;
   logic [2:0]        sweep_reg;
   logic              cfg_pending_q;
   logic [7:0]        kbd_q;
   logic              last_step;

   // Full-width compare: a shrunken cfg_len below the current index is not
   // caught here, so the counter rolls over naturally before matching.
   assign last_step = (step_idx_q == bus.cfg_len);

   // Pattern memory: whole-array clear on reset, otherwise writable in any state
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (bus.pat_we) begin
         mem[bus.pat_addr] <= bus.pat_data;
      end
   end

   // Configuration latch; a new request wins over the clear in LOAD_LOOP so it is not lost
   always_ff @(posedge clk) begin
      if (rst) begin
         freq_reg      <= '0;
         sweep_reg     <= '0;
         cfg_pending_q <= 1'b0;
      end else if (bus.cfg_req) begin
         freq_reg      <= bus.freq_sel;
         sweep_reg     <= bus.sweep_sel;
         cfg_pending_q <= 1'b1;
      end else if (state == LOAD_LOOP) begin
         cfg_pending_q <= 1'b0;
      end
   end

`ifdef SEQ_SCHED_ONESHOT_EN
   logic done_q, done_nxt;
`endif

   // Next-state and step counter; stop always takes precedence over start and bar_tick
   always_comb begin
      state_nxt = state;
      step_nxt  = step_idx_q;
`ifdef SEQ_SCHED_ONESHOT_EN
      done_nxt  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               state_nxt = LOAD_SND;
               step_nxt  = '0;
            end
         end
         LOAD_SND:  state_nxt = bus.stop ? IDLE : LOAD_LOOP;
         LOAD_LOOP: state_nxt = bus.stop ? IDLE : PLAY;
         PLAY: begin
            if (bus.stop) begin
               state_nxt = IDLE;
            end else if (bus.bar_tick) begin
               step_nxt = last_step ? '0 : step_idx_q + IDX_ONE;
`ifdef SEQ_SCHED_ONESHOT_EN
               if (last_step) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else if (cfg_pending_q) begin
                  state_nxt = LOAD_SND;
               end
`else
               if (cfg_pending_q) state_nxt = LOAD_SND;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counter and registered step-mask output
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         step_idx_q <= '0;
         kbd_q      <= '0;
      end else begin
         state      <= state_nxt;
         step_idx_q <= step_nxt;
         kbd_q      <= (state == PLAY) ? mem[step_idx_q] : 8'h00;
      end
   end

`ifdef SEQ_SCHED_ONESHOT_EN
   // End-of-run pulse, one cycle wide
   always_ff @(posedge clk) begin
      if (rst) done_q <= 1'b0;
      else     done_q <= done_nxt;
   end
   assign bus.done = done_q;
`else
   assign bus.done = 1'b0;
`endif

   // Load strobes and index bus, driven only in the two load states
   always_comb begin
      bus.freqin_out   = 8'h00;
      bus.sel_snd_out  = 1'b0;
      bus.sel_loop_out = 1'b0;
      case (state)
         LOAD_SND: begin
            bus.freqin_out  = {4'b0, freq_reg};
            bus.sel_snd_out = 1'b1;
         end
         LOAD_LOOP: begin
            bus.freqin_out   = {5'b0, sweep_reg};
            bus.sel_loop_out = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.kbd_out     = kbd_q;
   assign bus.step_idx    = step_idx_q;
   assign bus.busy        = (state != IDLE);
   assign bus.cfg_pending = cfg_pending_q;
endmodule

// File: doc/seq_pattern_scheduler.md
SEQ_PATTERN_SCHEDULER -- requirements
Module: seq_pattern_scheduler

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, giving the pattern-memory address width (2**ADDR_W entries).
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock; one clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- pat_we  in  1  pattern-memory write strobe.
- pat_addr  in  ADDR_W  write address.
- pat_data  in  8  step mask written.
- cfg_len  in  ADDR_W  index of the last pattern played.
- start  in  1  one-cycle start pulse.
- stop  in  1  one-cycle stop pulse.
- bar_tick  in  1  one-cycle end-of-bar pulse from the sequencer (scroll wrap).
- cfg_req  in  1  strobe that latches freq_sel and sweep_sel.
- freq_sel  in  4  tone index, 0..15.
- sweep_sel  in  3  sweep index, 0..7.
- kbd_out  out  8  current step mask to the sequencer kbd_in.
- freqin_out  out  8  index bus to the sequencer freqin.
- sel_snd_out  out  1  tone-load strobe.
- sel_loop_out  out  1  sweep-load strobe.
- step_idx  out  ADDR_W  current pattern index.
- busy  out  1  high in any state other than IDLE.
- cfg_pending  out  1  a latched configuration is waiting for a bar boundary.
- done  out  1  one-cycle end-of-run pulse.

Function
REQ-003 The FSM SHALL have four states: IDLE, LOAD_SND, LOAD_LOOP, PLAY.
REQ-004 In IDLE, a start pulse with stop low SHALL go to LOAD_SND and clear step_idx to 0.
REQ-005 LOAD_SND SHALL last exactly 1 cycle, drive freqin_out = {4'b0, freq_reg} and sel_snd_out = 1, then go to LOAD_LOOP.
REQ-006 LOAD_LOOP SHALL last exactly 1 cycle, drive freqin_out = {5'b0, sweep_reg} and sel_loop_out = 1, clear cfg_pending, then go to PLAY.
REQ-007 In all other cycles, sel_snd_out, sel_loop_out and freqin_out SHALL be 0.
REQ-008 A cfg_req pulse in any state SHALL load freq_reg and sweep_reg and set cfg_pending; a later cfg_req before the values are applied SHALL overwrite them.
REQ-009 In PLAY, bar_tick SHALL advance step_idx by 1, and from step_idx == cfg_len it SHALL wrap to 0.
REQ-010 A bar_tick in PLAY while cfg_pending = 1 SHALL advance step_idx and go to LOAD_SND; the FSM returns to PLAY 2 cycles later.
REQ-011 bar_tick outside PLAY SHALL be ignored.
REQ-012 kbd_out SHALL be registered with 1-cycle latency: kbd_out(n+1) = mem[step_idx(n)] when state(n) = PLAY, else 0.
REQ-013 kbd_out SHALL be 0 during LOAD_SND and LOAD_LOOP (1 cycle later, per REQ-012).
REQ-014 pat_we SHALL write mem[pat_addr] in every state.
REQ-015 A write to the entry currently playing SHALL appear on kbd_out 2 cycles after pat_we.
REQ-016 A stop pulse in any non-IDLE state SHALL go to IDLE on the next edge and leave step_idx unchanged.
REQ-017 When start and stop occur together, stop SHALL win.
REQ-018 A start pulse while busy SHALL be ignored.
REQ-019 If cfg_len > 2**ADDR_W-1 it is unrepresentable; the block SHALL compare cfg_len to step_idx at full width with no saturation.
REQ-020 If cfg_len changes to a value below step_idx during PLAY, the next bar_tick SHALL advance normally until the counter reaches cfg_len or wraps naturally.

Reset
REQ-021 rst SHALL take priority over every other input.
REQ-022 On rst the block SHALL set: state IDLE; step_idx 0; kbd_out 0; freqin_out 0; sel_snd_out 0; sel_loop_out 0; busy 0; done 0.
REQ-023 On rst the block SHALL set cfg_pending 0, freq_reg 0 and sweep_reg 0.
REQ-024 On rst the block SHALL clear all memory entries to 0 (sequentially cleared entries are not acceptable; all entries are zero on the cycle after rst).
REQ-025 rst asserted mid-PLAY SHALL force these values on the next edge; no pending load survives.

Configuration
REQ-026 The macro SEQ_SCHED_ONESHOT_EN SHALL select the end-of-run behaviour.
REQ-027 With SEQ_SCHED_ONESHOT_EN defined, a bar_tick in PLAY with step_idx == cfg_len SHALL wrap step_idx to 0, go to IDLE (cfg_pending ignored) and pulse done for 1 cycle.
REQ-028 Without SEQ_SCHED_ONESHOT_EN, playback SHALL loop indefinitely and done SHALL be tied to 0.

Verification
REQ-029 Reset, then start: sel_snd_out = 1 with freqin_out = 0 in cycle 1; sel_loop_out = 1 in cycle 2; busy = 1; kbd_out = 0 until PLAY.
REQ-030 Write mem[0..2] = 8'h81, 8'h3C, 8'hFF; cfg_len = 2; start; 4 bar_ticks: kbd_out sequence 81, 3C, FF, 81, 3C.
REQ-031 cfg_req with freq_sel = 15 and sweep_sel = 7 mid-bar: cfg_pending = 1; at the next bar_tick, freqin_out = 8'h0F with sel_snd_out, then freqin_out = 8'h07 with sel_loop_out; cfg_pending = 0.
REQ-032 Start and stop in the same cycle in IDLE: busy stays 0. Stop in PLAY: IDLE next cycle, kbd_out = 0 one cycle later.
REQ-033 With SEQ_SCHED_ONESHOT_EN, cfg_len = 1, two bar_ticks: done pulses once, busy = 0, step_idx = 0.
REQ-034 Assert rst mid-PLAY with cfg_pending = 1: all outputs take their reset values next cycle, and memory reads back 0.
